// File: rtl/sos_win_pkg.sv
// Shared constants for the 3x3 sum-of-squares window cache.
// Tap slice indices (row-major, NW oldest row/column) and counter width helper.
package sos_win_pkg;

  localparam int TAP_NW = 0;
  localparam int TAP_N  = 1;
  localparam int TAP_NE = 2;
  localparam int TAP_W  = 3;
  localparam int TAP_C  = 4;
  localparam int TAP_E  = 5;
  localparam int TAP_SW = 6;
  localparam int TAP_S  = 7;
  localparam int TAP_SE = 8;

  // Width of a counter covering 0..n-1, never below one bit.
  function automatic int pos_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sos_line_buf.sv
// One-row line buffer: COLS x DATA_W distributed RAM, shared address.
// Ports: clk, we, addr (column), wdata; rdata is an asynchronous read.
module sos_line_buf
  import sos_win_pkg::*;
#(
  parameter int DATA_W = 35,
  parameter int COLS   = 34
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [pos_w(COLS)-1:0]   addr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [COLS];

  // Read-before-write: rdata shows the old word during the write cycle.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/sos_window_cache.sv
// 3x3 sliding window over a raster stream of per-cell sum-of-squares values.
// Ports: aclk, arest_n (sync, active-low), sos_valid/sos_sof/sum_of_squares in;
// window_valid, win_data (9 taps), frame_done, frame_err out;
// win_row/win_col centre position only when SOS_WIN_POS_EN is defined.
module sos_window_cache
  import sos_win_pkg::*;
#(
  parameter int DATA_W = 35,
  parameter int COLS   = 34,
  parameter int ROWS   = 34,
  parameter int DELAY  = 1
) (
  input  logic                     aclk,
  input  logic                     arest_n,
  input  logic                     sos_valid,
  input  logic                     sos_sof,
  input  logic [DATA_W-1:0]        sum_of_squares,
  output logic                     window_valid,
  output logic [9*DATA_W-1:0]      win_data,
  output logic                     frame_done,
`ifdef SOS_WIN_POS_EN
  output logic [pos_w(ROWS)-1:0]   win_row,
  output logic [pos_w(COLS)-1:0]   win_col,
`endif
  output logic                     frame_err
);

  localparam int CW = pos_w(COLS);
  localparam int RW = pos_w(ROWS);

  // DELAY only shapes simulation timing; registers here use none.
  if (DELAY < 0) begin : g_delay_chk
    $error("DELAY must be non-negative");
  end

  logic [CW-1:0]     col;
  logic [RW-1:0]     row;
  logic [CW-1:0]     cur_col;
  logic [RW-1:0]     cur_row;
  logic              sof_hit;
  logic              col_last;
  logic              row_last;
  logic              win_hit;
  logic [DATA_W-1:0] lb1_rd;
  logic [DATA_W-1:0] lb2_rd;
  logic [DATA_W-1:0] top [3];
  logic [DATA_W-1:0] mid [3];
  logic [DATA_W-1:0] bot [3];

  assign sof_hit = sos_valid & sos_sof;

  // Start-of-frame overrides the tracked position for this sample.
  always_comb begin
    cur_col = col;
    cur_row = row;
    if (sof_hit) begin
      cur_col = '0;
      cur_row = '0;
    end
  end

  assign col_last = (cur_col == CW'(COLS - 1));
  assign row_last = (cur_row == RW'(ROWS - 1));

  // Sample (r+1,c+1) completes the window centred on (r,c).
  assign win_hit = sos_valid
                 && (cur_row >= RW'(2))
                 && (cur_col >= CW'(2));

  sos_line_buf #(
    .DATA_W (DATA_W),
    .COLS   (COLS)
  ) u_lb1 (
    .clk   (aclk),
    .we    (sos_valid),
    .addr  (cur_col),
    .wdata (sum_of_squares),
    .rdata (lb1_rd)
  );

  sos_line_buf #(
    .DATA_W (DATA_W),
    .COLS   (COLS)
  ) u_lb2 (
    .clk   (aclk),
    .we    (sos_valid),
    .addr  (cur_col),
    .wdata (lb1_rd),
    .rdata (lb2_rd)
  );

  always_ff @(posedge aclk) begin
    if (!arest_n) begin
      col          <= '0;
      row          <= '0;
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        top[i] <= '0;
        mid[i] <= '0;
        bot[i] <= '0;
      end
`ifdef SOS_WIN_POS_EN
      win_row      <= '0;
      win_col      <= '0;
`endif
    end else begin
      window_valid <= win_hit;
      frame_done   <= win_hit & row_last & col_last;
      if (sof_hit && (row != '0 || col != '0)) begin
        frame_err <= 1'b1;
      end
      if (sos_valid) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : cur_row + 1'b1;
        end else begin
          col <= cur_col + 1'b1;
          row <= cur_row;
        end
        // Index 0 is the oldest column (dc=-1), index 2 the newest.
        top[0] <= top[1];
        top[1] <= top[2];
        top[2] <= lb2_rd;
        mid[0] <= mid[1];
        mid[1] <= mid[2];
        mid[2] <= lb1_rd;
        bot[0] <= bot[1];
        bot[1] <= bot[2];
        bot[2] <= sum_of_squares;
      end
`ifdef SOS_WIN_POS_EN
      if (win_hit) begin
        win_row <= cur_row - 1'b1;
        win_col <= cur_col - 1'b1;
      end
`endif
    end
  end

  assign win_data[TAP_NW*DATA_W +: DATA_W] = top[0];
  assign win_data[TAP_N *DATA_W +: DATA_W] = top[1];
  assign win_data[TAP_NE*DATA_W +: DATA_W] = top[2];
  assign win_data[TAP_W *DATA_W +: DATA_W] = mid[0];
  assign win_data[TAP_C *DATA_W +: DATA_W] = mid[1];
  assign win_data[TAP_E *DATA_W +: DATA_W] = mid[2];
  assign win_data[TAP_SW*DATA_W +: DATA_W] = bot[0];
  assign win_data[TAP_S *DATA_W +: DATA_W] = bot[1];
  assign win_data[TAP_SE*DATA_W +: DATA_W] = bot[2];

endmodule

// File: tb/tb_sos_window_cache.sv
// Bench for sos_window_cache: 6x5 frames, image-array reference model.
// Covers reset, latency, gaps, back-to-back frames, sof error, mid reset.
module tb_sos_window_cache;

  localparam int DW   = 35;
  localparam int COLS = 6;
  localparam int ROWS = 5;
  localparam int RW   = $clog2(ROWS);
  localparam int CW   = $clog2(COLS);

  logic              clk = 1'b0;
  logic              arest_n;
  logic              sos_valid;
  logic              sos_sof;
  logic [DW-1:0]     sum_of_squares;
  logic              window_valid;
  logic [9*DW-1:0]   win_data;
  logic              frame_done;
  logic              frame_err;
`ifdef SOS_WIN_POS_EN
  logic [RW-1:0]     win_row;
  logic [CW-1:0]     win_col;
`endif

  always #5 clk = ~clk;

  sos_window_cache #(
    .DATA_W (DW),
    .COLS   (COLS),
    .ROWS   (ROWS),
    .DELAY  (1)
  ) dut (
    .aclk           (clk),
    .arest_n        (arest_n),
    .sos_valid      (sos_valid),
    .sos_sof        (sos_sof),
    .sum_of_squares (sum_of_squares),
    .window_valid   (window_valid),
    .win_data       (win_data),
    .frame_done     (frame_done),
`ifdef SOS_WIN_POS_EN
    .win_row        (win_row),
    .win_col        (win_col),
`endif
    .frame_err      (frame_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference: the frame as a 2D image; a window is read straight from it.
  int            mr, mc;
  logic [DW-1:0] img [ROWS][COLS];
  bit            exp_v, exp_done;
  int            exp_r, exp_c;
  logic [9*DW-1:0] exp_win, prev_win;

  task automatic step(input bit v, input bit sof, input logic [DW-1:0] d);
    sos_valid = v;
    sos_sof = sof;
    sum_of_squares = d;
    exp_v = 1'b0;
    exp_done = 1'b0;
    if (v) begin
      if (sof) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        exp_v = 1'b1;
        exp_r = mr - 1;
        exp_c = mc - 1;
        exp_done = (mr == ROWS - 1) && (mc == COLS - 1);
        for (int k = 0; k < 9; k++)
          exp_win[k*DW +: DW] = img[mr-2+k/3][mc-2+k%3];
      end
      mc++;
      if (mc == COLS) begin
        mc = 0;
        mr++;
        if (mr == ROWS) mr = 0;
      end
    end
    prev_win = win_data;
    @(posedge clk);
    #1;
    sos_valid = 1'b0;
    sos_sof = 1'b0;
    sum_of_squares = '0;
  endtask

  task automatic test_reset;
    arest_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (window_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %0b want 0", window_valid);
    end
    checks++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL rst_done got %0b want 0", frame_done);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got %0b want 0", frame_err);
    end
    checks++;
    if (win_data !== '0) begin
      errors++;
      $display("FAIL rst_data got %h want 0", win_data);
    end
    arest_n = 1'b1;
    mr = 0;
    mc = 0;
  endtask

  task automatic test_basic;
    int nwin = 0;
    int ndone = 0;
    bit first = 1'b1;
    int fv [9] = '{0, 1, 2, 100, 101, 102, 200, 201, 202};
    logic [9*DW-1:0] fc;
    for (int k = 0; k < 9; k++) fc[k*DW +: DW] = DW'(fv[k]);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        step(1'b1, r == 0 && c == 0, DW'(100*r + c));
        checks++;
        if (window_valid !== exp_v) begin
          errors++;
          $display("FAIL basic_valid r%0d c%0d got %0b want %0b",
                   r, c, window_valid, exp_v);
        end
        checks++;
        if (frame_done !== exp_done) begin
          errors++;
          $display("FAIL basic_done r%0d c%0d got %0b want %0b",
                   r, c, frame_done, exp_done);
        end
        if (window_valid) nwin++;
        if (frame_done) ndone++;
        if (exp_v) begin
          checks++;
          if (win_data !== exp_win) begin
            errors++;
            $display("FAIL basic_data r%0d c%0d got %h want %h",
                     r, c, win_data, exp_win);
          end
`ifdef SOS_WIN_POS_EN
          checks++;
          if (win_row !== RW'(exp_r) || win_col !== CW'(exp_c)) begin
            errors++;
            $display("FAIL basic_pos got %0d,%0d want %0d,%0d",
                     win_row, win_col, exp_r, exp_c);
          end
          if (frame_done) begin
            checks++;
            if (win_row !== RW'(3) || win_col !== CW'(4)) begin
              errors++;
              $display("FAIL done_pos got %0d,%0d want 3,4",
                       win_row, win_col);
            end
          end
`endif
        end
        if (window_valid && first) begin
          first = 1'b0;
          checks++;
          if (win_data !== fc || r != 2 || c != 2) begin
            errors++;
            $display("FAIL first_win at r%0d c%0d got %h want %h",
                     r, c, win_data, fc);
          end
        end
      end
    end
    checks++;
    if (nwin !== 12) begin
      errors++;
      $display("FAIL win_count got %0d want 12", nwin);
    end
    checks++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL done_count got %0d want 1", ndone);
    end
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL aligned_sof_err got %0b want 0", frame_err);
    end
  endtask

  task automatic test_gaps;
    int nwin;
    logic [DW-1:0] d;
    for (int f = 0; f < 2; f++) begin
      nwin = 0;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          for (int g = $urandom_range(5, 0); g > 0; g--) begin
            step(1'b0, 1'b0, DW'({$urandom, $urandom}));
            checks++;
            if (window_valid !== 1'b0 || frame_done !== 1'b0 ||
                win_data !== prev_win) begin
              errors++;
              $display("FAIL gap_hold v%0b d%0b got %h want %h",
                       window_valid, frame_done, win_data, prev_win);
            end
          end
          d = (f == 0) ? DW'(100*r + c) : DW'({$urandom, $urandom});
          step(1'b1, r == 0 && c == 0, d);
          checks++;
          if (window_valid !== exp_v || frame_done !== exp_done) begin
            errors++;
            $display("FAIL gap_valid r%0d c%0d got %0b%0b want %0b%0b",
                     r, c, window_valid, frame_done, exp_v, exp_done);
          end
          if (window_valid) nwin++;
          if (exp_v) begin
            checks++;
            if (win_data !== exp_win) begin
              errors++;
              $display("FAIL gap_data r%0d c%0d got %h want %h",
                       r, c, win_data, exp_win);
            end
          end
        end
      end
      checks++;
      if (nwin !== 12) begin
        errors++;
        $display("FAIL gap_count f%0d got %0d want 12", f, nwin);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit first = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          step(1'b1, r == 0 && c == 0, DW'(1000*f + 100*r + c));
          checks++;
          if (window_valid !== exp_v || frame_done !== exp_done) begin
            errors++;
            $display("FAIL b2b_valid f%0d r%0d c%0d got %0b%0b want %0b%0b",
                     f, r, c, window_valid, frame_done, exp_v, exp_done);
          end
          if (exp_v) begin
            checks++;
            if (win_data !== exp_win) begin
              errors++;
              $display("FAIL b2b_data f%0d r%0d c%0d got %h want %h",
                       f, r, c, win_data, exp_win);
            end
          end
          if (f == 1 && window_valid) begin
            for (int k = 0; k < 9; k++) begin
              checks++;
              if (win_data[k*DW +: DW] < DW'(1000)) begin
                errors++;
                $display("FAIL b2b_stale tap%0d got %0d want >=1000",
                         k, win_data[k*DW +: DW]);
              end
            end
            if (first) begin
              first = 1'b0;
              checks++;
              if (win_data[4*DW +: DW] !== DW'(1101)) begin
                errors++;
                $display("FAIL b2b_first got %0d want 1101",
                         win_data[4*DW +: DW]);
              end
            end
          end
        end
      end
    end
  endtask

  task automatic test_sof_err;
    for (int i = 0; i < 2*COLS + 3; i++)
      step(1'b1, i == 0, DW'(100*mr + mc));
    // Sample (2,3) arrives with a misplaced start-of-frame.
    step(1'b1, 1'b1, DW'(5000));
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL sof_err_rise got %0b want 1", frame_err);
    end
    checks++;
    if (window_valid !== 1'b0) begin
      errors++;
      $display("FAIL sof_realign_valid got %0b want 0", window_valid);
    end
    for (int i = 1; i < ROWS*COLS; i++) begin
      step(1'b1, 1'b0, DW'(5000 + 100*mr + mc));
      checks++;
      if (window_valid !== exp_v || frame_done !== exp_done) begin
        errors++;
        $display("FAIL sof_valid i%0d got %0b%0b want %0b%0b",
                 i, window_valid, frame_done, exp_v, exp_done);
      end
      if (exp_v) begin
        checks++;
        if (win_data !== exp_win) begin
          errors++;
          $display("FAIL sof_data i%0d got %h want %h",
                   i, win_data, exp_win);
        end
      end
    end
    checks++;
    if (frame_err !== 1'b1) begin
      errors++;
      $display("FAIL sof_err_sticky got %0b want 1", frame_err);
    end
  endtask

  task automatic test_reset_mid;
    int nwin = 0;
    for (int i = 0; i < 3*COLS + 2; i++)
      step(1'b1, i == 0, DW'({$urandom, $urandom}));
    arest_n = 1'b0;
    @(posedge clk);
    #1;
    arest_n = 1'b1;
    mr = 0;
    mc = 0;
    checks++;
    if (window_valid !== 1'b0 || frame_done !== 1'b0 ||
        frame_err !== 1'b0 || win_data !== '0) begin
      errors++;
      $display("FAIL mid_rst got %0b%0b%0b %h want 000 0",
               window_valid, frame_done, frame_err, win_data);
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        step(1'b1, r == 0 && c == 0, DW'({$urandom, $urandom}));
        checks++;
        if (window_valid !== exp_v || frame_done !== exp_done) begin
          errors++;
          $display("FAIL rst_valid r%0d c%0d got %0b%0b want %0b%0b",
                   r, c, window_valid, frame_done, exp_v, exp_done);
        end
        if (window_valid) nwin++;
        if (exp_v) begin
          checks++;
          if (win_data !== exp_win) begin
            errors++;
            $display("FAIL rst_data r%0d c%0d got %h want %h",
                     r, c, win_data, exp_win);
          end
        end
      end
    end
    checks++;
    if (nwin !== 12) begin
      errors++;
      $display("FAIL rst_count got %0d want 12", nwin);
    end
  endtask

  initial begin
    arest_n = 1'b0;
    sos_valid = 1'b0;
    sos_sof = 1'b0;
    sum_of_squares = '0;
    mr = 0;
    mc = 0;
    test_reset();
    test_basic();
    test_gaps();
    test_back_to_back();
    test_sof_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
